// File: rtl/sm4_dat_unpack.sv
// rtl/sm4_dat_unpack.sv - buffers 128-bit blocks and streams them out as WORD_W-bit words, MS word first
module sm4_dat_unpack #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     CLK_i,
    input  logic                     RST_N_i,
    input  logic [127:0]             DAT_i,
    input  logic                     DAT_VALID_i,
    output logic [WORD_W-1:0]        WORD_o,
    output logic                     WORD_VALID_o,
    input  logic                     WORD_READY_i,
    output logic                     WORD_LAST_o,
    output logic [$clog2(DEPTH):0]   LEVEL_o,
    output logic                     OVF_o,
    input  logic                     OVF_CLR_i
);

    localparam int N  = 128 / WORD_W;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nxt;
    logic [KW-1:0] k, k_nxt;
    logic          ovf;
    state_t        state, state_nxt;

    logic k_last, pop, pop_last, wr_ok;

    assign k_last   = (k == KW'(N - 1));
    assign pop      = WORD_VALID_o & WORD_READY_i;
    assign pop_last = pop & k_last;
    // A full buffer still takes a block when the same edge frees the head entry.
    assign wr_ok    = DAT_VALID_i & ((level != LW'(DEPTH)) | pop_last);

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        k_nxt     = k;
        case (state)
            IDLE: if (wr_ok) state_nxt = SEND;
            SEND: if (pop_last && level == LW'(1) && !wr_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        case ({wr_ok, pop_last})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
        if (pop) k_nxt = pop_last ? '0 : k + KW'(1);
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state  <= IDLE;
            level  <= '0;
            k      <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            k     <= k_nxt;
            if (wr_ok)    wr_ptr <= wr_ptr + PW'(1);
            if (pop_last) rd_ptr <= rd_ptr + PW'(1);
            if (DAT_VALID_i && !wr_ok) ovf <= 1'b1;
            else if (OVF_CLR_i)        ovf <= 1'b0;
        end
    end

    // Block storage carries no reset; validity comes from the level/state registers.
    always_ff @(posedge CLK_i) begin
        if (wr_ok) mem[wr_ptr] <= DAT_i;
    end

    assign WORD_VALID_o = (state == SEND);
    assign WORD_LAST_o  = WORD_VALID_o & k_last;
    assign WORD_o       = WORD_VALID_o ? mem[rd_ptr][127 - int'(k) * WORD_W -: WORD_W] : '0;
    assign LEVEL_o      = level;
    assign OVF_o        = ovf;

endmodule

// File: tb/tb_sm4_dat_unpack.sv
// tb/tb_sm4_dat_unpack.sv - scoreboard bench for sm4_dat_unpack, WORD_W=32, DEPTH=2
module tb_sm4_dat_unpack;

    localparam int W  = 32;
    localparam int NW = 128 / W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] dat;
    logic         dat_valid;
    logic [W-1:0] word;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [1:0]   level;
    logic         ovf;
    logic         ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W:0] exp_q [$];

    localparam logic [127:0] BLK_T1 = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] BLK_T2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] BLK_A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] BLK_B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] BLK_C  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [127:0] BLK_D  = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

    sm4_dat_unpack #(.WORD_W(W), .DEPTH(2)) dut (
        .CLK_i        (clk),
        .RST_N_i      (rst_n),
        .DAT_i        (dat),
        .DAT_VALID_i  (dat_valid),
        .WORD_o       (word),
        .WORD_VALID_o (word_valid),
        .WORD_READY_i (word_ready),
        .WORD_LAST_o  (word_last),
        .LEVEL_o      (level),
        .OVF_o        (ovf),
        .OVF_CLR_i    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < NW; i++) exp_q.push_back({i == NW - 1, b[127 - i * W -: W]});
    endtask

    task automatic send_block(input logic [127:0] b, input bit accept);
        dat       = b;
        dat_valid = 1'b1;
        if (accept) push_block(b);
        cyc();
        dat_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
        check(tag, 128'(exp_q.size()), 128'd0);
    endtask

    // Every popped word must match the head of the scoreboard, including its last flag.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {95'd0, word_last, word}, 128'h1_0000_0000_0000_0000);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("word", 128'(word), 128'(e[W-1:0]));
                check("last", 128'(word_last), 128'(e[W]));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        dat        = '0;
        dat_valid  = 1'b0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) cyc();
        check("rst_valid", 128'(word_valid), 128'd0);
        check("rst_last",  128'(word_last),  128'd0);
        check("rst_level", 128'(level),      128'd0);
        check("rst_ovf",   128'(ovf),        128'd0);
        check("rst_word",  128'(word),       128'd0);
        rst_n = 1'b1;
        cyc();

        // 1) single block, streaming at full rate
        word_ready = 1'b1;
        send_block(BLK_T1, 1'b1);
        check("t1_level1", 128'(level), 128'd1);
        check("t1_first",  128'(word),  128'h681EDF34);
        repeat (3) cyc();
        check("t1_last4",  128'(word_last), 128'd1);
        check("t1_level1b", 128'(level), 128'd1);
        cyc();
        check("t1_level0", 128'(level), 128'd0);
        check("t1_valid0", 128'(word_valid), 128'd0);
        check("t1_drained", 128'(exp_q.size()), 128'd0);

        // 2) backpressure, then alternating ready
        word_ready = 1'b0;
        send_block(BLK_T2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold", {word_valid, word_last, word}, {1'b1, 1'b0, 32'h01234567});
            cyc();
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            word_ready = ~word_ready;
            cyc();
        end
        word_ready = 1'b0;
        check("t2_drained", 128'(exp_q.size()), 128'd0);
        cyc();
        check("t2_level0", 128'(level), 128'd0);

        // 3) fill and overflow; set wins over a simultaneous clear
        send_block(BLK_A, 1'b1);
        send_block(BLK_B, 1'b1);
        check("t3_full", 128'(level), 128'd2);
        check("t3_ovf_pre", 128'(ovf), 128'd0);
        send_block(BLK_C, 1'b0);
        check("t3_level", 128'(level), 128'd2);
        check("t3_ovf", 128'(ovf), 128'd1);
        ovf_clr = 1'b1;
        send_block(BLK_C, 1'b0);
        ovf_clr = 1'b0;
        check("t3_ovf_prio", 128'(ovf), 128'd1);
        word_ready = 1'b1;
        wait_drain("t3_drain", 20);
        cyc();
        word_ready = 1'b0;
        check("t3_level0", 128'(level), 128'd0);
        check("t3_ovf_sticky", 128'(ovf), 128'd1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 128'(ovf), 128'd0);

        // 4) pass-through write on the final-word pop of a full buffer
        send_block(BLK_A, 1'b1);
        send_block(BLK_B, 1'b1);
        word_ready = 1'b1;
        repeat (3) cyc();
        check("t4_a_last", 128'(word_last), 128'd1);
        check("t4_a_full", 128'(level), 128'd2);
        send_block(BLK_C, 1'b1);
        check("t4_ovf", 128'(ovf), 128'd0);
        check("t4_level", 128'(level), 128'd2);
        check("t4_b_head", 128'(word), 128'hB0B1B2B3);
        wait_drain("t4_drain", 20);
        cyc();
        check("t4_level0", 128'(level), 128'd0);

        // 5) asynchronous reset after two words of A
        word_ready = 1'b0;
        send_block(BLK_A, 1'b1);
        word_ready = 1'b1;
        repeat (2) cyc();
        word_ready = 1'b0;
        check("t5_third", 128'(word), 128'hA8A9AAAB);
        #3 rst_n = 1'b0;
        #1;
        check("t5_valid", 128'(word_valid), 128'd0);
        check("t5_level", 128'(level), 128'd0);
        check("t5_ovf",   128'(ovf),   128'd0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        cyc();
        check("t5_idle", 128'(word_valid), 128'd0);
        send_block(BLK_D, 1'b1);
        check("t5_d_first", 128'(word), 128'hD0D1D2D3);
        word_ready = 1'b1;
        wait_drain("t5_drain", 20);
        cyc();
        check("t5_level0", 128'(level), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
